// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive stage: synchronizes sclk/mosi/cs into clk, assembles
// MSB-first words and presents them on a one-deep valid/ready register.
module spi_slave_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             cs,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_shift;
  logic [WIDTH-1:0]       r_out_data;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_cs_s;
  logic w_sclk_rise;
  logic w_full;
  logic w_accept;

  // cs synchronizer resets to the idle (high) level so reset never looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_full      = (r_cnt == CW'(WIDTH));
  assign w_accept    = ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_cs_s) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= S_RECV;
            r_busy  <= 1'b1;
          end
        end
        S_RECV: begin
          if (w_full) begin
            // A commit that lands with the handshake overrides the drop above
            if (w_accept) begin
              r_out_data  <= r_shift;
              r_out_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
            r_state <= S_TAIL;
          end else if (w_cs_s) begin
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[WIDTH-2:0], w_mosi_s};
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_TAIL: begin
          if (w_cs_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed scenarios plus random frames checked
// against a word-level model (accepted-word queue and pulse counts).
module tb_spi_slave_rx;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sclk = 1'b0;
  logic             mosi = 1'b0;
  logic             cs = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  spi_slave_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs        (cs),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Observe away from the active edge: count pulses and record handshakes
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one cs-low window with n bits (MSB of the n-bit field first)
  task automatic send_frame(input logic [63:0] bits, input int n,
                            input bit raise_cs, input bit ready_at_commit);
    cs = 1'b0;
    mosi = 1'b0;
    cyc(5);
    for (int i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      cyc(5);
      sclk = 1'b1;
      if (ready_at_commit && i == WIDTH - 1) begin
        cyc(3);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        cyc(1);
      end else begin
        cyc(5);
      end
      if (i == 1) chk("busy_mid", {31'd0, busy}, 32'd1);
      sclk = 1'b0;
    end
    cyc(5);
    if (raise_cs) begin
      cs = 1'b1;
      cyc(10);
    end
  endtask

  task automatic expect_word(input string tag);
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int e_ferr;
    int e_ovr;
    cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(3);

    // Single frame, consumer always ready
    out_ready = 1'b1;
    send_frame({32'd0, 32'hA5A5_F00F}, 32, 1'b1, 1'b0);
    exp_q.push_back(32'hA5A5_F00F);
    expect_word("t1_word");
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_ferr", n_ferr, 0);
    chk("t1_ovr", n_ovr, 0);

    // Back-to-back frames with no consumer: second word dropped
    out_ready = 1'b0;
    send_frame({32'd0, 32'h1234_5678}, 32, 1'b1, 1'b0);
    send_frame({32'd0, 32'hDEAD_BEEF}, 32, 1'b1, 1'b0);
    chk("t2_data", out_data, 32'h1234_5678);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_ovr", n_ovr, 1);
    out_ready = 1'b1;
    cyc(3);
    exp_q.push_back(32'h1234_5678);
    expect_word("t2_word");

    // Consumer accepts exactly in the commit cycle of the next frame
    out_ready = 1'b0;
    send_frame({32'd0, 32'hFFFF_0000}, 32, 1'b1, 1'b0);
    send_frame({32'd0, 32'h0000_FFFF}, 32, 1'b1, 1'b1);
    chk("t3_ovr", n_ovr, 1);
    chk("t3_data", out_data, 32'h0000_FFFF);
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    cyc(3);
    exp_q.push_back(32'hFFFF_0000);
    exp_q.push_back(32'h0000_FFFF);
    expect_word("t3_word");

    // Aborted frame after 17 bits, then a good frame
    send_frame({32'd0, 32'h0001_2345}, 17, 1'b1, 1'b0);
    chk("t4_ferr", n_ferr, 1);
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_none", got_q.size(), 0);
    send_frame({32'd0, 32'h8000_0001}, 32, 1'b1, 1'b0);
    exp_q.push_back(32'h8000_0001);
    expect_word("t4_word");

    // Extra sclk rises past WIDTH are ignored
    send_frame({28'd0, 32'hCAFE_BABE, 4'hF}, 36, 1'b1, 1'b0);
    exp_q.push_back(32'hCAFE_BABE);
    expect_word("t5_word");
    chk("t5_ferr", n_ferr, 1);

    // Reset mid-frame, then a clean frame
    send_frame({32'd0, 32'h0000_03A5}, 10, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(2);
    check_reset_outputs("t6_rst");
    cs = 1'b1;
    sclk = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("t6_ferr", n_ferr, 1);
    send_frame({32'd0, 32'h0F0F_0F0F}, 32, 1'b1, 1'b0);
    exp_q.push_back(32'h0F0F_0F0F);
    expect_word("t6_word");

    // Random mix of full frames (with trailing bits) and aborts, ready held
    e_ferr = n_ferr;
    e_ovr  = n_ovr;
    for (int k = 0; k < 12; k++) begin
      logic [31:0] w;
      int extra;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        int nb;
        nb = $urandom_range(0, WIDTH - 1);
        send_frame({32'd0, w}, nb, 1'b1, 1'b0);
        e_ferr++;
      end else begin
        logic [3:0] tail;
        extra = $urandom_range(0, 3);
        tail = 4'($urandom);
        send_frame(({28'd0, w, 4'd0} | {60'd0, tail}) >> (4 - extra), WIDTH + extra, 1'b1, 1'b0);
        exp_q.push_back(w);
      end
    end
    expect_word("rnd_word");
    chk("rnd_ferr", n_ferr, e_ferr);
    chk("rnd_ovr", n_ovr, e_ovr);

    // Random burst with no consumer: only the first word survives
    begin
      int nf;
      logic [31:0] first;
      out_ready = 1'b0;
      nf = $urandom_range(2, 4);
      for (int k = 0; k < nf; k++) begin
        logic [31:0] w;
        w = $urandom;
        if (k == 0) first = w;
        send_frame({32'd0, w}, 32, 1'b1, 1'b0);
      end
      chk("burst_ovr", n_ovr, e_ovr + nf - 1);
      chk("burst_data", out_data, first);
      out_ready = 1'b1;
      cyc(3);
      exp_q.push_back(first);
      expect_word("burst_word");
      chk("burst_valid", {31'd0, out_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI receive stage that sits directly downstream of the team's 32-bit SPI master and consumes its `sclk`/`mosi`/`cs` lines. It oversamples the serial lines in the local `clk` domain and assembles MSB-first words. Each completed word is presented on a one-deep valid/ready output register. Malformed frames and dropped words are flagged with single-cycle pulses.

## Interface
- `WIDTH`, 32: bits per frame.
- `SYNC_STAGES`, 2: synchronizer flops on each of `sclk`, `mosi`, `cs` (minimum 2).
- `clk` input 1: system clock; all logic is clocked on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sclk` input 1: serial clock from the master (mode 0); asynchronous to `clk`.
- `mosi` input 1: serial data; the master changes it on falling `sclk`.
- `cs` input 1: chip select, active low; idles high.
- `out_data` output WIDTH: last accepted word.
- `out_valid` output 1: `out_data` holds an unconsumed word.
- `out_ready` input 1: consumer accepts `out_data` when `out_valid && out_ready`.
- `busy` output 1: high while a frame is being received.
- `frame_err` output 1: one-cycle pulse when `cs` deasserts mid-frame.
- `overrun` output 1: one-cycle pulse when a completed word is dropped.

## Operation
- Every serial input passes through a `SYNC_STAGES` synchronizer. The synchronized values are written `sclk_s`, `mosi_s`, `cs_s`.
- One extra flop on `sclk_s` provides edge detection: `sclk_rise = sclk_s & ~sclk_d`.
- FSM states:
  - **IDLE**:
    - `busy` = 0.
    - When `cs_s` = 0: clear the bit counter and shift register, then go to RECV.
  - **RECV**:
    - `busy` = 1.
    - On `sclk_rise`: `shift <= {shift[WIDTH-2:0], mosi_s}` and `cnt <= cnt + 1`.
    - When the rise that makes `cnt` == WIDTH occurs: the next cycle performs the word commit, then the FSM goes to TAIL.
    - If `cs_s` = 1 with `cnt` < WIDTH: pulse `frame_err`, discard the partial word, go to IDLE.
    - The `cnt == 0` case also counts as a mid-frame abort and raises `frame_err`.
  - **TAIL**:
    - `busy` = 1.
    - Further `sclk_rise` events are ignored; no extra bits are shifted.
    - When `cs_s` = 1, go to IDLE. `frame_err` is not raised here.
- Word commit:
  - If `out_valid` = 0, or `out_ready` = 1 in the same cycle: `out_data <= shift` and `out_valid <= 1`.
  - Otherwise: `out_data` is kept unchanged, the new word is discarded, and `overrun` pulses.
- Output handshake:
  - `out_valid` drops the cycle after `out_valid && out_ready`, unless a commit lands in that same cycle.
  - `out_data` is stable while `out_valid` = 1.
- Bit counter width is `$clog2(WIDTH+1)`. It saturates at WIDTH and never wraps.

## Timing
- Reset values:
  - Outputs: `out_data` = 0, `out_valid` = 0, `busy` = 0, `frame_err` = 0, `overrun` = 0.
  - Internal: FSM = IDLE.
  - Synchronizers: `sclk` stages to 0, `cs` stages to 1.
- Reset asserted mid-frame aborts the frame immediately. After `rst_n` rises, reception resumes at the next `cs` falling edge seen in IDLE.
- Latency is counted from the first `clk` edge that captures the 32nd `sclk` high:
  - `sclk_rise` is seen `SYNC_STAGES` edges later.
  - Bit shifted at the same edge as `sclk_rise`.
  - `out_valid` rises one edge later: 4 `clk` edges in total with the defaults.
- `busy` rises `SYNC_STAGES`+1 edges after `cs` is first sampled low.
- Input constraint: each `sclk` high and low phase lasts at least 3 `clk` periods; the master provides 5.
- `mosi` must be stable for at least `SYNC_STAGES`+1 `clk` periods around rising `sclk`. The master guarantees this by changing it on the falling edge.
- Each pulse output (`frame_err`, `overrun`) is exactly one `clk` cycle wide, per event.

## Test plan
- Single frame 0xA5A5_F00F, `out_ready` held 1 → `out_valid` pulses 1 cycle with `out_data` = 0xA5A5_F00F; `busy` returns to 0 after `cs` rises; no error pulses.
- Two back-to-back frames 0x1234_5678 then 0xDEAD_BEEF, `out_ready` = 0 throughout → `out_data` = 0x1234_5678, `out_valid` = 1, one `overrun` pulse at the second commit.
- Frame 0xFFFF_0000 with `out_ready` raised in the same cycle as the commit of the next frame 0x0000_FFFF → no `overrun`; `out_data` becomes 0x0000_FFFF.
- `cs` raised after 17 `sclk` rises → one `frame_err` pulse, `out_valid` stays 0; the following full frame 0x8000_0001 is received correctly.
- 36 `sclk` rises within one `cs`-low window carrying 0xCAFE_BABE followed by 4 ones → `out_data` = 0xCAFE_BABE; extra bits ignored; no `frame_err`.
- `rst_n` pulsed low after 10 bits → all outputs return to their reset values; the next frame 0x0F0F_0F0F is received correctly.
